// File: rtl/alu_op_arbiter.sv
// Two-requester round-robin front end for a small shared ALU.
// One op in flight; logic ops take one cycle, multiply runs a WIDTH-step shift-add.
module alu_op_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [2:0]         req0_op,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [2:0]         req1_op,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t            state;
  logic              last_grant;
  logic              grant;
  logic              accept;
  logic [2:0]        sel_op;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [WIDTH:0]    addsub;
  logic [WIDTH-1:0]  logic_r;
  logic [RW-1:0]     alu_res;
  logic              alu_err;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     acc;
  logic [RW-1:0]     acc_next;

  // Round-robin grant: alternate when both valid, otherwise follow the lone requester.
  always_comb begin
    grant = ~last_grant;
    if (req0_valid && !req1_valid)      grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
  end

  assign req0_ready = rst_n && (state == IDLE) && !grant;
  assign req1_ready = rst_n && (state == IDLE) &&  grant;
  assign accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

  assign sel_op = grant ? req1_op : req0_op;
  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;

  // Single-cycle ops; add/sub at WIDTH+1 bits so the borrow wraps there, not at RW.
  always_comb begin
    addsub  = '0;
    logic_r = '0;
    alu_res = '0;
    alu_err = 1'b0;
    case (sel_op)
      3'b000: begin
        addsub  = {1'b0, sel_a} + {1'b0, sel_b};
        alu_res = RW'(addsub);
      end
      3'b001: begin
        addsub  = {1'b0, sel_a} - {1'b0, sel_b};
        alu_res = RW'(addsub);
      end
      3'b010: begin
        logic_r = sel_a ^ sel_b;
        alu_res = RW'(logic_r);
      end
      3'b011: begin
        logic_r = sel_a & sel_b;
        alu_res = RW'(logic_r);
      end
      3'b100: begin
        logic_r = sel_a | sel_b;
        alu_res = RW'(logic_r);
      end
      3'b101: begin
        logic_r = ~sel_a;
        alu_res = RW'(logic_r);
      end
      3'b111:  alu_err = 1'b1;
      default: alu_res = '0;
    endcase
  end

  assign acc_next = b_q[cnt] ? (acc + (RW'(a_q) << cnt)) : acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      acc        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            rsp_id     <= grant;
            busy       <= 1'b1;
            if (sel_op == 3'b110) begin
              state <= MUL;
              a_q   <= sel_a;
              b_q   <= sel_b;
              cnt   <= '0;
              acc   <= '0;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= alu_res;
              rsp_err   <= alu_err;
            end
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= acc_next;
            rsp_err   <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Randomized self-checking bench for alu_op_arbiter against an arithmetic reference model.
module tb_alu_op_arbiter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [2*W-1:0] rsp_data;

  int n_cmp = 0;
  int n_bad = 0;
  bit lg;  // model of which requester was granted last

  alu_op_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_res(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0: return 8'(ia + ib);
      3'd1: return 8'((ia - ib + 32) % 32);
      3'd2: return 8'(ia ^ ib);
      3'd3: return 8'(ia & ib);
      3'd4: return 8'(ia | ib);
      3'd5: return 8'(15 - ia);
      3'd6: return 8'(ia * ib);
      default: return 8'd0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lg = 1'b1;
  endtask

  // Drives one op, waits for accept and response; returns what it observed.
  task automatic run_op(input int r, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input int hold, output bit acc, output int lat, output logic id,
                        output logic [7:0] data, output logic err, output bit stable);
    int n;
    acc = 0; lat = 0; id = 0; data = 0; err = 0; stable = 1;
    @(negedge clk);
    rsp_ready = (hold == 0);
    if (r == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    n = 0;
    while (!(r == 0 ? req0_ready : req1_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    acc = (r == 0) ? req0_ready : req1_ready;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!acc) return;
    #1;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    id = rsp_id; data = rsp_data; err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      if (!rsp_valid || rsp_id !== id || rsp_data !== data || rsp_err !== err ||
          req0_ready || req1_ready) stable = 0;
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err, busy, req0_ready, req1_ready} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b id=%b d=%h e=%b busy=%b r0=%b r1=%b, want all 0",
               rsp_valid, rsp_id, rsp_data, rsp_err, busy, req0_ready, req1_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    lg = 1'b1;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_grant: got r0=%b r1=%b, want r0=1 r1=0", req0_ready, req1_ready);
    end
  endtask

  task automatic check_op(input string name, input int r, input logic [2:0] op,
                          input logic [3:0] a, input logic [3:0] b, input int hold);
    bit acc, stable; int lat; logic id, err; logic [7:0] data;
    int exp_lat;
    run_op(r, op, a, b, hold, acc, lat, id, data, err, stable);
    exp_lat = (op == 3'd6) ? 1 + W : 1;
    n_cmp++;
    if (!acc || lat != exp_lat || id !== 1'(r) || data !== ref_res(op, a, b) ||
        err !== (op == 3'd7) || !stable) begin
      n_bad++;
      $display("FAIL %s: got acc=%0d lat=%0d id=%b data=%h err=%b stable=%0d, want acc=1 lat=%0d id=%0d data=%h err=%0d stable=1",
               name, acc, lat, id, data, err, stable, exp_lat, r, ref_res(op, a, b), op == 3'd7);
    end
    if (acc) lg = 1'(r);
  endtask

  task automatic test_directed();
    check_op("t1_add", 0, 3'd0, 4'b1000, 4'b0100, 0);
    check_op("t2_sub_wrap", 1, 3'd1, 4'b0011, 4'b0101, 0);
    check_op("t3_mul", 0, 3'd6, 4'b1100, 4'b0010, 0);
    check_op("t3_mul_max", 1, 3'd6, 4'hF, 4'hF, 0);
    check_op("t6_illegal", 0, 3'd7, 4'h9, 4'h3, 0);
    check_op("inv", 1, 3'd5, 4'h6, 4'h0, 0);
    n_cmp++;
    if (ref_res(3'd1, 4'b0011, 4'b0101) !== 8'h1E) begin
      n_bad++;
      $display("FAIL model_sub: got %h want 1e", ref_res(3'd1, 4'b0011, 4'b0101));
    end
  endtask

  task automatic test_backpressure();
    check_op("t5_hold_sub", 1, 3'd1, 4'h2, 4'h9, 3);
    check_op("t5_hold_mul", 0, 3'd6, 4'h7, 4'hB, 3);
    @(negedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_release: got v=%b busy=%b, want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] q[$];
    logic [8:0] e;
    logic [3:0] a0, b0, a1, b1;
    bit w;
    int n0, n1;
    n0 = 0; n1 = 0;
    do_reset();
    rsp_ready = 1'b1;
    a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 3'd2; req0_a = a0; req0_b = b0;
      req1_valid = 1'b1; req1_op = 3'd2; req1_a = a1; req1_b = b1;
      #1;
      if (rsp_valid) begin
        e = (q.size() > 0) ? q.pop_front() : 9'h1FF;
        n_cmp++;
        if ({rsp_id, rsp_data} !== e) begin
          n_bad++;
          $display("FAIL t4_rsp: got id=%b data=%h, want id=%b data=%h", rsp_id, rsp_data, e[8], e[7:0]);
        end
      end
      if (req0_ready || req1_ready) begin
        w = req1_ready;
        n_cmp++;
        if ((req0_ready && req1_ready) || w != !lg) begin
          n_bad++;
          $display("FAIL t4_grant: got r0=%b r1=%b, want winner %0d", req0_ready, req1_ready, !lg);
        end
        lg = w;
        if (w) begin
          q.push_back({1'b1, ref_res(3'd2, a1, b1)});
          n1++; a1 = 4'($urandom); b1 = 4'($urandom);
        end else begin
          q.push_back({1'b0, ref_res(3'd2, a0, b0)});
          n0++; a0 = 4'($urandom); b0 = 4'($urandom);
        end
      end
    end
    // Operands stay as issued until the accepting edge; update them only after it.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (rsp_valid && q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if ({rsp_id, rsp_data} !== e) begin
          n_bad++;
          $display("FAIL t4_drain: got id=%b data=%h, want id=%b data=%h", rsp_id, rsp_data, e[8], e[7:0]);
        end
      end
    end
    n_cmp++;
    if (q.size() != 0 || n0 + n1 < 10 || n0 - n1 > 1 || n1 - n0 > 1) begin
      n_bad++;
      $display("FAIL t4_fairness: got n0=%0d n1=%0d left=%0d, want balanced and none left", n0, n1, q.size());
    end
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'd6; req0_a = 4'hF; req0_b = 4'hF;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL t6_mul_busy: got busy=%b v=%b, want 1 0", busy, rsp_valid);
    end
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 3'd2; req1_op = 3'd2;
    @(negedge clk); #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err, busy, req0_ready, req1_ready} !== 14'd0) begin
      n_bad++;
      $display("FAIL t6_reset_mid_mul: got v=%b id=%b d=%h e=%b busy=%b r0=%b r1=%b, want all 0",
               rsp_valid, rsp_id, rsp_data, rsp_err, busy, req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    lg = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) seen = 1;
    end
    n_cmp++;
    if (seen || req0_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL t6_no_response: got seen=%0d r0=%b, want seen=0 r0=1", seen, req0_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      check_op("random", int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    lg = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_round_robin();
    test_reset_mid_mul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
